rgb_fader: RTL and testbench
============================

# rgb_fader

Upstream colour-fade controller for the three-channel PWM LED driver. It accepts a target RGB duty triple through a valid/ready handshake and ramps its registered duty outputs linearly toward the target in fixed steps at a programmable tick rate. Its `red_duty`/`green_duty`/`blue_duty` outputs connect directly to the matching inputs of the RGB PWM driver. It pulses `done` when all three channels reach the target.

## Interface
- `R`, 8: duty resolution; duties are R+1 bits, and full scale is 2^R (256 = 100 %).
- `TICK_DIV`, 50000: clock cycles per fade step (≥2).
- `STEP`, 1: maximum duty change per channel per tick (1 … 2^R).

- `clk`  in  1  system clock, single domain.
- `reset`  in  1  synchronous, active-high reset.
- `tgt_valid`  in  1  target triple offered.
- `tgt_ready`  out  1  block accepts a target; high only in IDLE.
- `tgt_red`, `tgt_green`, `tgt_blue`  in  R+1 each  target duties.
- `red_duty`, `green_duty`, `blue_duty`  out  R+1 each  registered current duties, to the PWM driver.
- `busy`  out  1  high in FADE.
- `done`  out  1  one-cycle pulse on fade completion.

## Operation
- State machine: IDLE, FADE.
- IDLE:
  - `tgt_ready`=1.
  - If `tgt_valid` is high on a rising edge, the block latches the target triple (clamped, see Configuration), clears the tick counter to 0, and enters FADE.
- FADE:
  - `tgt_ready`=0; `tgt_valid` and the target inputs are ignored.
  - The tick counter (width $clog2(TICK_DIV)) counts 0 … TICK_DIV-1 and wraps.
  - A tick occurs on the edge where counter==TICK_DIV-1.
  - Per channel on each tick:
    - if cur<tgt: cur ← cur + min(STEP, tgt-cur);
    - if cur>tgt: cur ← cur - min(STEP, cur-tgt);
    - else unchanged.
  - Channels step independently, so a channel never overshoots its target.
  - Arithmetic uses the difference, computed at R+2 bits, so nothing wraps.
  - Completion check: in any FADE cycle where all three cur==tgt, the next edge sets state←IDLE and `done`←1 for exactly one cycle. No step occurs on that edge.
  - If the target already equals the current duties at acceptance, the block spends one cycle in FADE and then pulses `done`.
- Duties hold their value in IDLE; new targets start from the current duties, not from 0.
- `busy` = (state==FADE).

## Timing
- Reset values:
  - state IDLE;
  - all duties 0;
  - tick counter 0;
  - `done`=0, `busy`=0, `tgt_ready`=1.
- Reset during FADE aborts the fade immediately and forces all duties to 0.
- Accept on edge E0: `busy`=1 from E0.
  - First step lands on edge E0+TICK_DIV; subsequent steps land every TICK_DIV cycles.
- Fade length: N = ceil(max channel |Δ| / STEP) ticks. The last step is at E0+N·TICK_DIV.
  - `done`=1 in the cycle after edge E0+N·TICK_DIV+1.
  - `tgt_ready` returns high in that same cycle.
- Accept with Δ=0: `done` rises at E0+1.
- The earliest new acceptance is on the edge ending the `done` cycle. Back-to-back targets therefore have a one-cycle gap.
- All outputs are registered except `tgt_ready` and `busy`, which are decoded directly from the state register.

## Configuration
- `RGB_FADER_CLAMP_EN` defined:
  - each target is clamped to 2^R at acceptance (inputs in 2^R+1 … 2^(R+1)-1 latch as 2^R);
  - duties never exceed full scale.
- Not defined:
  - targets are latched unmodified;
  - duties may exceed 2^R, and the PWM driver holds such channels at 100 %.

## Test plan
- Parameters: R=8, TICK_DIV=4, STEP=3 unless noted.
- Reset then idle: `reset`=1 for 2 cycles → duties 0/0/0, `tgt_ready`=1, `busy`=0, `done`=0.
- Fade up: accept (10,0,0) at E0 → red = 3, 6, 9, 10 at E4, E8, E12, E16; `done` pulse in the cycle after E17; green/blue stay 0.
- Mixed direction: from (10,0,0), accept (1,5,0) → red 7, 4, 1 and green 3, 5, both moving on the same ticks; `done` after 3 ticks; no overshoot.
- Zero-delta target: accept (1,5,0) while at (1,5,0) → `busy` for 1 cycle; `done` at E0+1; duties unchanged.
- Handshake and abort:
  - `tgt_valid` held high during FADE → no second acceptance until `tgt_ready` returns.
  - `reset` asserted mid-fade → duties 0 next edge, state IDLE.
- Clamp: accept (300,0,0) with STEP=256 → red=256 with macro defined; red=300 without.

Source files
------------

// File: rtl/rgb_fader_if.sv
// rgb_fader_if: target handshake and duty/status bundle for rgb_fader.
// master = target source / PWM-side consumer, slave = the fader itself.
interface rgb_fader_if #(
  parameter int R = 8
);
  logic       tgt_valid;
  logic       tgt_ready;
  logic [R:0] tgt_red;
  logic [R:0] tgt_green;
  logic [R:0] tgt_blue;
  logic [R:0] red_duty;
  logic [R:0] green_duty;
  logic [R:0] blue_duty;
  logic       busy;
  logic       done;

  modport master (
    output tgt_valid, tgt_red, tgt_green, tgt_blue,
    input  tgt_ready, red_duty, green_duty, blue_duty, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_red, tgt_green, tgt_blue,
    output tgt_ready, red_duty, green_duty, blue_duty, busy, done
  );
endinterface

// File: rtl/rgb_fader.sv
// rgb_fader: linear colour-fade controller feeding the RGB PWM driver.
// Accepts a target duty triple in IDLE, then steps each channel by up to
// STEP every TICK_DIV cycles until all three match, then pulses done.
// Optional build macro: RGB_FADER_CLAMP_EN clamps accepted targets to 2^R.
module rgb_fader #(
  parameter int R        = 8,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 1
) (
  input logic       clk,
  input logic       reset,
  rgb_fader_if.slave bus
);
  localparam int NCH = 3;
  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FADE = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [R+1:0]  STEP_W   = (R+2)'(STEP);
  localparam logic [R:0]    FULL     = {1'b1, {R{1'b0}}};

  logic [0:0]              state;
  logic [CW-1:0]           cnt;
  logic                    done_q;
  logic [NCH-1:0][R:0]     cur;
  logic [NCH-1:0][R:0]     tgt;
  logic [NCH-1:0][R:0]     tgt_raw;
  logic [NCH-1:0][R:0]     tgt_in;
  logic [NCH-1:0][R:0]     nxt;
  logic [NCH-1:0]          at_tgt;
  logic                    tick;

  // channel order: 0 = red, 1 = green, 2 = blue
  assign tgt_raw = {bus.tgt_blue, bus.tgt_green, bus.tgt_red};
  assign tick    = (cnt == CNT_LAST);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic [R+1:0] cur_w, tgt_w, d_up, d_dn, inc_up, inc_dn, sum_up, sum_dn;
    logic [R:0]   nxt_c;

`ifdef RGB_FADER_CLAMP_EN
    // anything above full scale latches as exactly full scale
    assign tgt_in[g] = (tgt_raw[g] > FULL) ? FULL : tgt_raw[g];
`else
    // targets pass through untouched; the PWM driver saturates above 2^R
    assign tgt_in[g] = tgt_raw[g];
`endif

    // one bit of headroom so differences and sums never wrap
    always_comb begin
      cur_w  = {1'b0, cur[g]};
      tgt_w  = {1'b0, tgt[g]};
      d_up   = tgt_w - cur_w;
      d_dn   = cur_w - tgt_w;
      inc_up = (d_up < STEP_W) ? d_up : STEP_W;
      inc_dn = (d_dn < STEP_W) ? d_dn : STEP_W;
      sum_up = cur_w + inc_up;
      sum_dn = cur_w - inc_dn;
      nxt_c  = cur[g];
      if (tgt_w > cur_w)      nxt_c = sum_up[R:0];
      else if (tgt_w < cur_w) nxt_c = sum_dn[R:0];
    end

    assign nxt[g]    = nxt_c;
    assign at_tgt[g] = (cur[g] == tgt[g]);
  end

  // state, tick counter, duties and the done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cur    <= '0;
      tgt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.tgt_valid) begin
            tgt   <= tgt_in;
            cnt   <= '0;
            state <= ST_FADE;
          end
        end
        ST_FADE: begin
          // completion wins over a coincident tick: no step on the exit edge
          if (&at_tgt) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) cur <= nxt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tgt_ready  = (state == ST_IDLE);
  assign bus.busy       = (state == ST_FADE);
  assign bus.done       = done_q;
  assign bus.red_duty   = cur[0];
  assign bus.green_duty = cur[1];
  assign bus.blue_duty  = cur[2];
endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader: directed, table-driven bench for rgb_fader.
// Main DUT: R=8, TICK_DIV=4, STEP=3. Second DUT with STEP=256 for the clamp case.
module tb_rgb_fader;
  localparam int R  = 8;
  localparam int TD = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rgb_fader_if #(.R(R)) bus ();
  rgb_fader_if #(.R(R)) cbus ();

  rgb_fader #(.R(R), .TICK_DIV(TD), .STEP(ST))  dut     (.clk(clk), .reset(reset), .bus(bus.slave));
  rgb_fader #(.R(R), .TICK_DIV(TD), .STEP(256)) u_clamp (.clk(clk), .reset(reset), .bus(cbus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance n rising edges, then sample on the following falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_duty(input string name, input logic [R:0] r, input logic [R:0] g, input logic [R:0] b);
    chk({name, ".red"},   32'(bus.red_duty),   32'(r));
    chk({name, ".green"}, 32'(bus.green_duty), 32'(g));
    chk({name, ".blue"},  32'(bus.blue_duty),  32'(b));
  endtask

  // per-step expected duties, index k = value after tick k+1
  typedef struct {
    logic [R:0]         tr, tg, tb;
    int                 n;
    logic [3:0][R:0]    er, eg, eb;
  } vec_t;

  vec_t vecs[4];
  logic [R:0] pr, pg, pb;
  logic [R:0] clamp_exp;

  initial begin
    // expected-step lists are written last-step first (index 3 .. 0)
    vecs[0] = '{9'd10, 9'd0, 9'd0, 4, {9'd10, 9'd9, 9'd6, 9'd3}, '0, '0};                                    // fade up
    vecs[1] = '{9'd1,  9'd5, 9'd0, 3, {9'd1, 9'd1, 9'd4, 9'd7}, {9'd5, 9'd5, 9'd5, 9'd3}, '0};              // mixed
    vecs[2] = '{9'd1,  9'd5, 9'd0, 0, {9'd1, 9'd1, 9'd1, 9'd1}, {9'd5, 9'd5, 9'd5, 9'd5}, '0};              // zero delta
    vecs[3] = '{9'd0,  9'd0, 9'd7, 3, '0, {9'd0, 9'd0, 9'd0, 9'd2}, {9'd7, 9'd7, 9'd6, 9'd3}};              // mixed, blue up

    reset = 1'b1;
    bus.tgt_valid = 1'b0;  bus.tgt_red = '0;  bus.tgt_green = '0;  bus.tgt_blue = '0;
    cbus.tgt_valid = 1'b0; cbus.tgt_red = '0; cbus.tgt_green = '0; cbus.tgt_blue = '0;

    // reset then idle
    step(2);
    chk_duty("reset", 9'd0, 9'd0, 9'd0);
    chk("reset.ready", 32'(bus.tgt_ready), 32'd1);
    chk("reset.busy",  32'(bus.busy),      32'd0);
    chk("reset.done",  32'(bus.done),      32'd0);
    reset = 1'b0;
    step(1);
    pr = '0; pg = '0; pb = '0;

    // table-driven fades
    for (int v = 0; v < 4; v++) begin
      for (int w = 0; w < 20 && !bus.tgt_ready; w++) step(1);
      chk($sformatf("v%0d.ready_before", v), 32'(bus.tgt_ready), 32'd1);
      bus.tgt_valid = 1'b1;
      bus.tgt_red = vecs[v].tr; bus.tgt_green = vecs[v].tg; bus.tgt_blue = vecs[v].tb;
      step(1);                               // after E0
      bus.tgt_valid = 1'b0;
      chk($sformatf("v%0d.busy_e0", v),  32'(bus.busy),      32'd1);
      chk($sformatf("v%0d.ready_e0", v), 32'(bus.tgt_ready), 32'd0);
      for (int k = 0; k < vecs[v].n; k++) begin
        step(TD - 1);                        // one cycle before the tick edge
        chk_duty($sformatf("v%0d.hold%0d", v, k), pr, pg, pb);
        step(1);                             // after the tick edge
        chk_duty($sformatf("v%0d.tick%0d", v, k), vecs[v].er[k], vecs[v].eg[k], vecs[v].eb[k]);
        pr = vecs[v].er[k]; pg = vecs[v].eg[k]; pb = vecs[v].eb[k];
      end
      chk($sformatf("v%0d.done_early", v), 32'(bus.done), 32'd0);
      chk($sformatf("v%0d.busy_last", v),  32'(bus.busy), 32'd1);
      step(1);
      chk($sformatf("v%0d.done", v),       32'(bus.done),      32'd1);
      chk($sformatf("v%0d.ready_done", v), 32'(bus.tgt_ready), 32'd1);
      chk($sformatf("v%0d.busy_done", v),  32'(bus.busy),      32'd0);
      chk_duty($sformatf("v%0d.final", v), pr, pg, pb);
      step(1);
      chk($sformatf("v%0d.done_pulse", v), 32'(bus.done), 32'd0);
    end

    // valid held high through a fade; mid-fade target change must be ignored
    bus.tgt_valid = 1'b1;
    bus.tgt_red = 9'd3; bus.tgt_green = 9'd3; bus.tgt_blue = 9'd3;
    step(1);
    chk("hold.busy_e0", 32'(bus.busy), 32'd1);
    step(4);
    chk_duty("hold.tick1", 9'd3, 9'd3, 9'd4);
    chk("hold.ready_mid", 32'(bus.tgt_ready), 32'd0);
    bus.tgt_red = 9'd100; bus.tgt_green = 9'd100; bus.tgt_blue = 9'd100;
    step(4);
    chk_duty("hold.tick2", 9'd3, 9'd3, 9'd3);
    chk("hold.ready_fade", 32'(bus.tgt_ready), 32'd0);
    step(1);
    chk("hold.done",  32'(bus.done),      32'd1);
    chk("hold.ready", 32'(bus.tgt_ready), 32'd1);
    step(1);                                 // re-accepted on the edge ending done
    chk("hold.busy_again", 32'(bus.busy), 32'd1);
    chk("hold.done_clear", 32'(bus.done), 32'd0);
    step(4);
    chk_duty("hold.new_tick", 9'd6, 9'd6, 9'd6);

    // abort mid-fade
    bus.tgt_valid = 1'b0;
    reset = 1'b1;
    step(1);
    chk_duty("abort", 9'd0, 9'd0, 9'd0);
    chk("abort.busy",  32'(bus.busy),      32'd0);
    chk("abort.ready", 32'(bus.tgt_ready), 32'd1);
    chk("abort.done",  32'(bus.done),      32'd0);
    reset = 1'b0;
    step(1);

    // clamp: STEP=256 instance, target 300
`ifdef RGB_FADER_CLAMP_EN
    clamp_exp = 9'd256;
`else
    clamp_exp = 9'd300;
`endif
    cbus.tgt_valid = 1'b1; cbus.tgt_red = 9'd300;
    step(1);
    cbus.tgt_valid = 1'b0;
    chk("clamp.busy_e0", 32'(cbus.busy), 32'd1);
    step(4);
    chk("clamp.tick1", 32'(cbus.red_duty), 32'd256);
    step(4);
    chk("clamp.final", 32'(cbus.red_duty),   32'(clamp_exp));
    chk("clamp.green", 32'(cbus.green_duty), 32'd0);
    step(2);
    chk("clamp.idle", 32'(cbus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
